// File: rtl/spi_pkg.sv
// Shared SPI types and default timing for the ADC-side SPI master and its driver.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_mst_state_t;

    localparam int SPI_WORD_W   = 16;
    localparam int SPI_CLK_DIV  = 4;
    localparam int SPI_CS_SETUP = 2;
    localparam int SPI_CS_HOLD  = 2;
    localparam int SPI_CS_GAP   = 4;

    function automatic int spi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: toggles sclk every CLK_DIV enabled cycles, starting high on the
// first enabled cycle; strobes mark the cycle whose edge makes sclk rise or fall.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic             sclk_q, sclk_d;
    logic             toggle;

    assign toggle = en && (phase_q == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        phase_d = '0;
        sclk_d  = 1'b0;
        if (en) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + CNT_W'(1);
            sclk_d  = toggle ? ~sclk_q : sclk_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk     = sclk_q;
    assign rise_stb = toggle && !sclk_q;
    assign fall_stb = toggle && sclk_q;

endmodule

// File: rtl/spi_master_rx.sv
// SPI master (CPOL=0, CPHA=1) that reads one DATA_W-bit word MSB-first per start request
// and presents it with a one-cycle data_valid strobe.
module spi_master_rx
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_WORD_W,
    parameter int CLK_DIV  = SPI_CLK_DIV,
    parameter int CS_SETUP = SPI_CS_SETUP,
    parameter int CS_HOLD  = SPI_CS_HOLD,
    parameter int CS_GAP   = SPI_CS_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int CNT_W = $clog2(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    if (DATA_W < 2 || CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 0) begin : g_bad_params
        $error("spi_master_rx: illegal parameters DATA_W=%0d CLK_DIV=%0d CS_SETUP=%0d CS_HOLD=%0d CS_GAP=%0d",
               DATA_W, CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    end

    spi_mst_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              cs_q, cs_d;
    logic              data_valid_q, data_valid_d;
    logic              rise_stb, fall_stb;
    logic              rise_stb_unused;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == SHIFT),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // The slave drives on rise; the master only needs the falling-edge sample point.
    assign rise_stb_unused = rise_stb;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        cs_d         = cs_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (fall_stb) begin
                    shift_d = {shift_q[DATA_W-2:0], miso};
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    cs_d         = 1'b1;
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift register is reset too, so an aborted transfer leaves no partial word behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            cs_q         <= 1'b1;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            cs_q         <= cs_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign cs         = cs_q;
    assign busy       = (state_q != IDLE);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule
